// File: rtl/core_pkg.sv
`default_nettype none
// ============================================================================
// core_pkg -- shared opcodes, register constants and EX FSM states
// Revision: 1.0
// ============================================================================
package core_pkg;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b100;
    localparam logic [2:0] ALU_NOR = 3'b101;
    localparam logic [2:0] ALU_SLL = 3'b110;
    localparam logic [2:0] ALU_MUL = 3'b111;

    localparam logic [4:0] REG_ZERO = 5'd0;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DONE = 2'd2
    } ex_state_t;

endpackage
`default_nettype wire

// File: rtl/ex_stage_seq_mult.sv
`default_nettype none
// ============================================================================
// seq_mult -- iterative shift-add multiplier, one partial product per cycle
// Revision: 1.0
// ============================================================================
module seq_mult
    import core_pkg::*;
#(
    parameter int DATA_W     = 32,
    parameter int MUL_CYCLES = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    input  logic [DATA_W-1:0] mcand,
    input  logic [DATA_W-1:0] mplier,
    output logic              busy,
    output logic              done,
    output logic              last,
    output logic [DATA_W-1:0] product
);

    localparam int CNT_W = (MUL_CYCLES > 1) ? $clog2(MUL_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MUL_CYCLES - 1);

    logic [DATA_W-1:0] mcand_reg;
    logic [DATA_W-1:0] mplier_reg;
    logic [DATA_W-1:0] acc;
    logic [CNT_W-1:0]  cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mcand_reg  <= '0;
            mplier_reg <= '0;
            acc        <= '0;
            cnt        <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else if (abort) begin
            mcand_reg  <= '0;
            mplier_reg <= '0;
            acc        <= '0;
            cnt        <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else if (start) begin
            mcand_reg  <= mcand;
            mplier_reg <= mplier;
            acc        <= '0;
            cnt        <= '0;
            busy       <= 1'b1;
            done       <= 1'b0;
        end else if (busy) begin
            // Only the low DATA_W bits of the product are kept, so mcand may shift out.
            if (mplier_reg[0]) begin
                acc <= acc + mcand_reg;
            end
            mcand_reg  <= mcand_reg << 1;
            mplier_reg <= mplier_reg >> 1;
            cnt        <= cnt + CNT_W'(1);
            if (last) begin
                busy <= 1'b0;
                done <= 1'b1;
            end
        end else begin
            done <= 1'b0;
        end
    end

    assign last    = busy && (cnt == CNT_LAST);
    assign product = acc;

endmodule
`default_nettype wire

// File: rtl/ex_stage.sv
`default_nettype none
// ============================================================================
// ex_stage -- MIPS execute stage: operand forwarding, ALU, sequential multiply
//             and the EX/MEM pipeline register
// Revision: 1.0
// ============================================================================
module ex_stage
    import core_pkg::*;
#(
    parameter int DATA_W     = 32,
    parameter int MUL_CYCLES = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] rg1,
    input  logic [DATA_W-1:0] rg2,
    input  logic [DATA_W-1:0] imm_val,
    input  logic [4:0]        dest_reg,
    input  logic [4:0]        rd_rg1,
    input  logic [4:0]        rd_rg2,
    input  logic [2:0]        alu_op,
    input  logic              alu_src,
    input  logic              reg_dst,
    input  logic              mem_wr,
    input  logic              mem_rd,
    input  logic              data_src,
    input  logic              wr_reg,
    input  logic              wb_wr_reg,
    input  logic [4:0]        wb_dest,
    input  logic [DATA_W-1:0] wb_data,
    input  logic              ex_flush,
    output logic              ex_busy,
    output logic [DATA_W-1:0] exmem_alu_res,
    output logic [DATA_W-1:0] exmem_store_data,
    output logic [4:0]        exmem_dest,
    output logic              exmem_mem_wr,
    output logic              exmem_mem_rd,
    output logic              exmem_data_src,
    output logic              exmem_wr_reg
);

    ex_state_t         state;
    ex_state_t         state_next;
    logic [DATA_W-1:0] fwd_rs;
    logic [DATA_W-1:0] fwd_rt;
    logic [DATA_W-1:0] op_a;
    logic [DATA_W-1:0] op_b;
    logic [DATA_W-1:0] alu_res;
    logic [DATA_W-1:0] product;
    logic [4:0]        dest_sel;
    logic              exmem_fwd_ok;
    logic              wb_fwd_ok;
    logic              mul_start;
    logic              mul_busy;
    logic              mul_done;
    logic              mul_last;

    // A load in EX/MEM has no data yet; the ID hazard unit stalls that case.
    assign exmem_fwd_ok = exmem_wr_reg && !exmem_mem_rd && (exmem_dest != REG_ZERO);
    assign wb_fwd_ok    = wb_wr_reg && (wb_dest != REG_ZERO);

    always_comb begin
        fwd_rs = rg1;
        if (exmem_fwd_ok && (exmem_dest == rd_rg1)) begin
            fwd_rs = exmem_alu_res;
        end else if (wb_fwd_ok && (wb_dest == rd_rg1)) begin
            fwd_rs = wb_data;
        end
    end

    always_comb begin
        fwd_rt = rg2;
        if (exmem_fwd_ok && (exmem_dest == rd_rg2)) begin
            fwd_rt = exmem_alu_res;
        end else if (wb_fwd_ok && (wb_dest == rd_rg2)) begin
            fwd_rt = wb_data;
        end
    end

    assign op_a     = fwd_rs;
    assign op_b     = alu_src ? imm_val : fwd_rt;
    assign dest_sel = reg_dst ? dest_reg : rd_rg2;

    always_comb begin
        alu_res = '0;
        case (alu_op)
            ALU_ADD: alu_res = op_a + op_b;
            ALU_SUB: alu_res = op_a - op_b;
            ALU_AND: alu_res = op_a & op_b;
            ALU_OR:  alu_res = op_a | op_b;
            ALU_SLT: alu_res = {{(DATA_W-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
            ALU_NOR: alu_res = ~(op_a | op_b);
            ALU_SLL: alu_res = op_b << op_a[4:0];
            default: alu_res = '0;
        endcase
    end

    seq_mult #(
        .DATA_W     (DATA_W),
        .MUL_CYCLES (MUL_CYCLES)
    ) u_seq_mult (
        .clk     (clk),
        .rst     (rst),
        .start   (mul_start),
        .abort   (ex_flush),
        .mcand   (op_a),
        .mplier  (op_b),
        .busy    (mul_busy),
        .done    (mul_done),
        .last    (mul_last),
        .product (product)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        ex_busy    = 1'b0;
        mul_start  = 1'b0;
        case (state)
            IDLE: begin
                if (alu_op == ALU_MUL) begin
                    ex_busy    = 1'b1;
                    mul_start  = 1'b1;
                    state_next = MUL;
                end
            end
            MUL: begin
                ex_busy = 1'b1;
                // Never stall in MUL if the multiplier is not actually running.
                if (mul_last || !mul_busy) begin
                    state_next = DONE;
                end
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
        if (ex_flush) begin
            ex_busy    = 1'b0;
            mul_start  = 1'b0;
            state_next = IDLE;
        end
    end

    // Every busy cycle and every flush pushes a bubble into EX/MEM.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            exmem_alu_res    <= '0;
            exmem_store_data <= '0;
            exmem_dest       <= '0;
            exmem_mem_wr     <= 1'b0;
            exmem_mem_rd     <= 1'b0;
            exmem_data_src   <= 1'b0;
            exmem_wr_reg     <= 1'b0;
        end else if (ex_flush || ex_busy) begin
            exmem_alu_res    <= '0;
            exmem_store_data <= '0;
            exmem_dest       <= '0;
            exmem_mem_wr     <= 1'b0;
            exmem_mem_rd     <= 1'b0;
            exmem_data_src   <= 1'b0;
            exmem_wr_reg     <= 1'b0;
        end else begin
            exmem_alu_res    <= ((state == DONE) && mul_done) ? product : alu_res;
            exmem_store_data <= fwd_rt;
            exmem_dest       <= dest_sel;
            exmem_mem_wr     <= mem_wr;
            exmem_mem_rd     <= mem_rd;
            exmem_data_src   <= data_src;
            exmem_wr_reg     <= wr_reg;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ex_stage.sv
`default_nettype none
// ============================================================================
// tb_ex_stage -- self-checking bench: vector table, multi-cycle sequences and
//                randomized instructions against a behavioural model
// Revision: 1.0
// ============================================================================
module tb_ex_stage;
    import core_pkg::*;

    localparam int DW = 32;
    localparam int MC = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic [DW-1:0] rg1, rg2, imm_val, wb_data;
    logic [4:0]    dest_reg, rd_rg1, rd_rg2, wb_dest;
    logic [2:0]    alu_op;
    logic          alu_src, reg_dst, mem_wr, mem_rd, data_src, wr_reg, wb_wr_reg, ex_flush;
    logic          ex_busy;
    logic [DW-1:0] exmem_alu_res, exmem_store_data;
    logic [4:0]    exmem_dest;
    logic          exmem_mem_wr, exmem_mem_rd, exmem_data_src, exmem_wr_reg;
    logic [3:0]    out_ctrl;

    always #5 clk = ~clk;

    ex_stage #(.DATA_W(DW), .MUL_CYCLES(MC)) dut (
        .clk(clk), .rst(rst), .rg1(rg1), .rg2(rg2), .imm_val(imm_val),
        .dest_reg(dest_reg), .rd_rg1(rd_rg1), .rd_rg2(rd_rg2), .alu_op(alu_op),
        .alu_src(alu_src), .reg_dst(reg_dst), .mem_wr(mem_wr), .mem_rd(mem_rd),
        .data_src(data_src), .wr_reg(wr_reg), .wb_wr_reg(wb_wr_reg), .wb_dest(wb_dest),
        .wb_data(wb_data), .ex_flush(ex_flush), .ex_busy(ex_busy),
        .exmem_alu_res(exmem_alu_res), .exmem_store_data(exmem_store_data),
        .exmem_dest(exmem_dest), .exmem_mem_wr(exmem_mem_wr), .exmem_mem_rd(exmem_mem_rd),
        .exmem_data_src(exmem_data_src), .exmem_wr_reg(exmem_wr_reg)
    );

    assign out_ctrl = {exmem_mem_wr, exmem_mem_rd, exmem_data_src, exmem_wr_reg};

    // ctrl = {mem_wr, mem_rd, data_src, wr_reg}
    typedef struct packed {
        logic [2:0]    op;
        logic [4:0]    rs, rt, rd;
        logic [DW-1:0] a, b, imm;
        logic          alu_src, reg_dst;
        logic [3:0]    ctrl;
        logic          wb_wr;
        logic [4:0]    wb_dest;
        logic [DW-1:0] wb_data;
    } instr_t;

    typedef struct packed {
        instr_t        in;
        logic [DW-1:0] exp_res;
        logic [4:0]    exp_dest;
    } vec_t;

    int checks = 0;
    int errors = 0;

    // Expected contents of the EX/MEM register
    logic [DW-1:0] m_res, m_sd;
    logic [4:0]    m_dest;
    logic [3:0]    m_ctrl;

    task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic chk_exmem(input string nm);
        chk({nm, "_res"},  exmem_alu_res,    m_res);
        chk({nm, "_sd"},   exmem_store_data, m_sd);
        chk({nm, "_dest"}, DW'(exmem_dest),  DW'(m_dest));
        chk({nm, "_ctrl"}, DW'(out_ctrl),    DW'(m_ctrl));
    endtask

    task automatic model_clear();
        m_res = '0; m_sd = '0; m_dest = '0; m_ctrl = '0;
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    function automatic logic [DW-1:0] ref_alu(input logic [2:0] op, input logic [DW-1:0] a, input logic [DW-1:0] b);
        case (op)
            3'd0: return a + b;
            3'd1: return a - b;
            3'd2: return a & b;
            3'd3: return a | b;
            3'd4: return ($signed(a) < $signed(b)) ? DW'(1) : DW'(0);
            3'd5: return ~(a | b);
            3'd6: return b << a[4:0];
            default: return a * b;
        endcase
    endfunction

    // The newest producer of a register wins; r0 and loads in flight never forward.
    function automatic logic [DW-1:0] fwd(input logic [4:0] idx, input logic [DW-1:0] raw, input instr_t i);
        if (m_ctrl[0] && !m_ctrl[2] && m_dest != 5'd0 && m_dest == idx) return m_res;
        if (i.wb_wr && i.wb_dest != 5'd0 && i.wb_dest == idx) return i.wb_data;
        return raw;
    endfunction

    task automatic model_issue(input instr_t i);
        logic [DW-1:0] a, rtv, b;
        a   = fwd(i.rs, i.a, i);
        rtv = fwd(i.rt, i.b, i);
        b   = i.alu_src ? i.imm : rtv;
        m_res  = ref_alu(i.op, a, b);
        m_sd   = rtv;
        m_dest = i.reg_dst ? i.rd : i.rt;
        m_ctrl = i.ctrl;
    endtask

    task automatic drive(input instr_t i);
        alu_op = i.op; rd_rg1 = i.rs; rd_rg2 = i.rt; dest_reg = i.rd;
        rg1 = i.a; rg2 = i.b; imm_val = i.imm; alu_src = i.alu_src; reg_dst = i.reg_dst;
        {mem_wr, mem_rd, data_src, wr_reg} = i.ctrl;
        wb_wr_reg = i.wb_wr; wb_dest = i.wb_dest; wb_data = i.wb_data;
    endtask

    function automatic instr_t mk(input logic [2:0] op, input logic [4:0] rs, input logic [4:0] rt,
                                  input logic [4:0] rd, input logic [DW-1:0] a, input logic [DW-1:0] b,
                                  input logic [DW-1:0] imm, input logic src, input logic rdst,
                                  input logic [3:0] ctrl, input logic wbw, input logic [4:0] wbd,
                                  input logic [DW-1:0] wbdata);
        instr_t i;
        i.op = op; i.rs = rs; i.rt = rt; i.rd = rd; i.a = a; i.b = b; i.imm = imm;
        i.alu_src = src; i.reg_dst = rdst; i.ctrl = ctrl;
        i.wb_wr = wbw; i.wb_dest = wbd; i.wb_data = wbdata;
        return i;
    endfunction

    function automatic vec_t mkv(input instr_t i, input logic [DW-1:0] r, input logic [4:0] d);
        vec_t v;
        v.in = i; v.exp_res = r; v.exp_dest = d;
        return v;
    endfunction

    function automatic instr_t rand_instr(input logic [2:0] op);
        return mk(op, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 31)),
                  DW'($urandom), DW'($urandom), DW'($urandom), 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
                  5'($urandom_range(0, 7)), DW'($urandom));
    endfunction

    task automatic run_single(input string nm, input instr_t i);
        drive(i);
        ex_flush = 1'b0;
        #1;
        chk({nm, "_busy"}, DW'(ex_busy), DW'(0));
        model_issue(i);
        tick();
        chk_exmem(nm);
    endtask

    // Holds the instruction while busy; the WB port is retargeted at rs to show
    // that operands were captured on the first edge.
    task automatic run_mul(input string nm, input instr_t i);
        logic [DW-1:0] a, b, prod, sd;
        int nb;
        drive(i);
        ex_flush = 1'b0;
        a    = fwd(i.rs, i.a, i);
        b    = i.alu_src ? i.imm : fwd(i.rt, i.b, i);
        prod = ref_alu(ALU_MUL, a, b);
        nb   = 0;
        #1;
        while (ex_busy && nb < MC + 8) begin
            nb++;
            tick();
            chk({nm, "_bubble"}, DW'(out_ctrl), DW'(0));
            i.wb_wr = 1'b1; i.wb_dest = i.rs; i.wb_data = i.wb_data + DW'(1);
            drive(i);
            #1;
        end
        chk({nm, "_busy_cycles"}, DW'(nb), DW'(MC + 1));
        model_clear();
        sd = fwd(i.rt, i.b, i);
        tick();
        m_res = prod; m_sd = sd; m_dest = i.reg_dst ? i.rd : i.rt; m_ctrl = i.ctrl;
        chk_exmem(nm);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete, errors so far %0d", errors);
        $fatal(1);
    end

    initial begin
        vec_t   tv[19];
        instr_t ins;

        tv[0]  = mkv(mk(ALU_ADD, 1, 2, 9, 5, 7, 0, 0, 0, 4'b0001, 0, 0, 0), 12, 2);
        tv[1]  = mkv(mk(ALU_ADD, 5, 6, 3, 10, 0, 0, 0, 1, 4'b0001, 0, 0, 0), 10, 3);
        tv[2]  = mkv(mk(ALU_ADD, 3, 7, 8, 0, 1, 0, 0, 1, 4'b0001, 0, 0, 0), 11, 8);
        tv[3]  = mkv(mk(ALU_ADD, 5, 6, 3, 10, 0, 0, 0, 1, 4'b0001, 0, 0, 0), 10, 3);
        tv[4]  = mkv(mk(ALU_ADD, 9, 9, 9, 0, 0, 0, 0, 1, 4'b0000, 0, 0, 0), 0, 9);
        tv[5]  = mkv(mk(ALU_ADD, 3, 7, 8, 0, 1, 0, 0, 1, 4'b0001, 1, 3, 10), 11, 8);
        tv[6]  = mkv(mk(ALU_ADD, 5, 6, 0, 20, 0, 0, 0, 1, 4'b0001, 0, 0, 0), 20, 0);
        tv[7]  = mkv(mk(ALU_ADD, 0, 7, 7, 1, 2, 0, 0, 0, 4'b0001, 1, 0, 99), 3, 7);
        tv[8]  = mkv(mk(ALU_ADD, 5, 6, 4, 20, 0, 0, 0, 1, 4'b0001, 0, 0, 0), 20, 4);
        tv[9]  = mkv(mk(ALU_SUB, 4, 5, 10, 0, 5, 0, 0, 1, 4'b1001, 1, 4, 30), 15, 10);
        tv[10] = mkv(mk(ALU_SLT, 11, 12, 13, 32'hFFFF_FFFF, 1, 0, 0, 1, 4'b0010, 0, 0, 0), 1, 13);
        tv[11] = mkv(mk(ALU_SLL, 11, 12, 14, 4, 1, 0, 0, 1, 4'b0001, 0, 0, 0), 16, 14);
        tv[12] = mkv(mk(ALU_ADD, 11, 12, 15, 32'h10, 5, 32'hFFFF_FFF0, 1, 1, 4'b0001, 0, 0, 0), 0, 15);
        tv[13] = mkv(mk(ALU_AND, 16, 17, 18, 32'hF0F0, 32'hFF00, 0, 0, 1, 4'b0001, 0, 0, 0), 32'hF000, 18);
        tv[14] = mkv(mk(ALU_OR, 16, 17, 19, 32'hF0F0, 32'hFF00, 0, 0, 1, 4'b0001, 0, 0, 0), 32'hFFF0, 19);
        tv[15] = mkv(mk(ALU_NOR, 16, 17, 20, 0, 0, 0, 0, 1, 4'b0001, 0, 0, 0), 32'hFFFF_FFFF, 20);
        tv[16] = mkv(mk(ALU_ADD, 16, 17, 21, 7, 0, 0, 0, 1, 4'b0111, 0, 0, 0), 7, 21);
        tv[17] = mkv(mk(ALU_ADD, 21, 16, 22, 1, 1, 0, 0, 1, 4'b0001, 0, 0, 0), 2, 22);
        tv[18] = mkv(mk(ALU_SUB, 23, 22, 24, 50, 0, 0, 0, 1, 4'b0001, 0, 0, 0), 48, 24);

        // Reset state
        rst = 1'b1;
        ex_flush = 1'b0;
        drive(mk(ALU_ADD, 0, 0, 0, 0, 0, 0, 0, 0, 4'b0000, 0, 0, 0));
        repeat (2) tick();
        model_clear();
        chk_exmem("reset");
        chk("reset_busy", DW'(ex_busy), DW'(0));
        rst = 1'b0;

        // Directed vector table
        for (int k = 0; k < 19; k++) begin
            drive(tv[k].in);
            model_issue(tv[k].in);
            tick();
            chk("tbl_res", exmem_alu_res, tv[k].exp_res);
            chk("tbl_dest", DW'(exmem_dest), DW'(tv[k].exp_dest));
            chk("tbl_ctrl", DW'(out_ctrl), DW'(tv[k].in.ctrl));
        end

        // Full multiply: 0xFFFFFFFF * 3
        run_mul("mul", mk(ALU_MUL, 27, 28, 26, 32'hFFFF_FFFF, 3, 0, 0, 1, 4'b0001, 0, 0, 0));
        chk("mul_const", exmem_alu_res, 32'hFFFF_FFFD);

        // Flush in the middle of a multiply
        drive(mk(ALU_MUL, 27, 28, 29, 7, 9, 0, 0, 1, 4'b0001, 0, 0, 0));
        #1;
        chk("flush_pre_busy", DW'(ex_busy), DW'(1));
        repeat (10) tick();
        ex_flush = 1'b1;
        #1;
        chk("flush_busy", DW'(ex_busy), DW'(0));
        tick();
        ex_flush = 1'b0;
        model_clear();
        chk_exmem("flush");
        run_single("post_flush", mk(ALU_ADD, 1, 2, 3, 2, 3, 0, 0, 1, 4'b0001, 0, 0, 0));

        // Asynchronous reset between edges clears a loaded EX/MEM at once
        #1;
        rst = 1'b1;
        #1;
        model_clear();
        chk_exmem("async_rst");
        #1;
        rst = 1'b0;

        // Reset in the middle of a multiply returns the stage to idle
        drive(mk(ALU_MUL, 5, 6, 7, 11, 13, 0, 0, 1, 4'b0001, 0, 0, 0));
        repeat (5) tick();
        #1;
        rst = 1'b1;
        #1;
        chk_exmem("mul_rst");
        rst = 1'b0;
        run_single("post_rst", mk(ALU_ADD, 1, 2, 3, 40, 2, 0, 0, 1, 4'b0001, 0, 0, 0));
        chk("post_rst_const", exmem_alu_res, 42);

        // Randomized instruction stream
        for (int n = 0; n < 300; n++) begin
            if (n % 50 == 25) begin
                run_mul("rmul", rand_instr(ALU_MUL));
            end
            if ($urandom_range(0, 9) == 0) begin
                ins = rand_instr(3'($urandom_range(0, 7)));
                drive(ins);
                ex_flush = 1'b1;
                #1;
                chk("rflush_busy", DW'(ex_busy), DW'(0));
                tick();
                ex_flush = 1'b0;
                model_clear();
                chk_exmem("rflush");
            end else begin
                run_single("rand", rand_instr(3'($urandom_range(0, 6))));
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
